// File: rtl/serial_receiver.sv
// Serial receiver: start bit (0), DATA_BITS data bits MSB first, stop bit (1).
// Define SERIAL_RX_STOP_CHECK_EN to add the STOP state and the stop-bit check.
module serial_receiver #(
    parameter int DATA_BITS = 8
) (
    input  logic                 dataClk,
    input  logic                 rst,
    input  logic                 serialDataIn,
    input  logic                 dataAck,
    output logic [DATA_BITS-1:0] parallelDataOut,
    output logic                 dataValid,
    output logic                 frameError,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

`ifdef SERIAL_RX_STOP_CHECK_EN
    typedef enum logic [1:0] {IDLE, SHIFT, STOP} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t               state;
    state_t               nextState;
    logic [CNT_W-1:0]     bitCount;
    logic [DATA_BITS-1:0] shiftReg;
    logic [DATA_BITS-1:0] shiftNext;
    logic [DATA_BITS-1:0] loadValue;
    logic                 startFrame;
    logic                 shiftEn;
    logic                 completeByte;
`ifdef SERIAL_RX_STOP_CHECK_EN
    logic                 badStop;
`endif

    assign shiftNext = (shiftReg << 1) | DATA_BITS'(serialDataIn);
    assign busy      = (state != IDLE);

    always_ff @(posedge dataClk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState    = state;
        startFrame   = 1'b0;
        shiftEn      = 1'b0;
        completeByte = 1'b0;
`ifdef SERIAL_RX_STOP_CHECK_EN
        badStop      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!serialDataIn) begin
                    nextState  = SHIFT;
                    startFrame = 1'b1;
                end
            end
            SHIFT: begin
                shiftEn = 1'b1;
                if (bitCount == LAST_BIT) begin
`ifdef SERIAL_RX_STOP_CHECK_EN
                    nextState = STOP;
`else
                    nextState    = IDLE;
                    completeByte = 1'b1;
`endif
                end
            end
`ifdef SERIAL_RX_STOP_CHECK_EN
            STOP: begin
                nextState = IDLE;
                if (serialDataIn) completeByte = 1'b1;
                else              badStop      = 1'b1;
            end
`endif
            default: nextState = IDLE;
        endcase
    end

    // With the stop check the byte is already assembled when STOP is reached;
    // without it the last data bit is merged in on the completing edge.
`ifdef SERIAL_RX_STOP_CHECK_EN
    assign loadValue = shiftReg;
`else
    assign loadValue = shiftNext;
`endif

    always_ff @(posedge dataClk or posedge rst) begin
        if (rst) begin
            bitCount <= '0;
            shiftReg <= '0;
        end else if (startFrame) begin
            bitCount <= '0;
        end else if (shiftEn) begin
            bitCount <= bitCount + CNT_W'(1);
            shiftReg <= shiftNext;
        end
    end

    // A completing byte wins over an acknowledge on the same edge, but the
    // acknowledge still clears overrun since the consumer took the old byte.
    always_ff @(posedge dataClk or posedge rst) begin
        if (rst) begin
            parallelDataOut <= '0;
            dataValid       <= 1'b0;
            overrun         <= 1'b0;
        end else if (completeByte) begin
            parallelDataOut <= loadValue;
            dataValid       <= 1'b1;
            if (dataAck)        overrun <= 1'b0;
            else if (dataValid) overrun <= 1'b1;
        end else if (dataAck && dataValid) begin
            dataValid <= 1'b0;
            overrun   <= 1'b0;
        end
    end

`ifdef SERIAL_RX_STOP_CHECK_EN
    always_ff @(posedge dataClk or posedge rst) begin
        if (rst) frameError <= 1'b0;
        else     frameError <= badStop;
    end
`else
    assign frameError = 1'b0;
`endif

endmodule

// File: tb/tb_serial_receiver.sv
// Self-checking bench for serial_receiver: directed frames plus random frames
// and random acknowledges, compared against a frame-level reference model.
module tb_serial_receiver;

    localparam int DB = 8;
`ifdef SERIAL_RX_STOP_CHECK_EN
    localparam logic STOP_CHECK = 1'b1;
`else
    localparam logic STOP_CHECK = 1'b0;
`endif

    logic          dataClk = 1'b0;
    logic          rst;
    logic          serialDataIn;
    logic          dataAck;
    logic [DB-1:0] parallelDataOut;
    logic          dataValid;
    logic          frameError;
    logic          overrun;
    logic          busy;

    int compared   = 0;
    int mismatched = 0;

    logic [DB-1:0] expData;
    logic          expValid;
    logic          expOverrun;
    logic          expFrameErr;
    logic          expBusy;

    serial_receiver #(.DATA_BITS(DB)) dut (
        .dataClk        (dataClk),
        .rst            (rst),
        .serialDataIn   (serialDataIn),
        .dataAck        (dataAck),
        .parallelDataOut(parallelDataOut),
        .dataValid      (dataValid),
        .frameError     (frameError),
        .overrun        (overrun),
        .busy           (busy)
    );

    always #5 dataClk = ~dataClk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".data"},     32'(parallelDataOut), 32'(expData));
        checkOutput({tag, ".valid"},    32'(dataValid),       32'(expValid));
        checkOutput({tag, ".overrun"},  32'(overrun),         32'(expOverrun));
        checkOutput({tag, ".frameErr"}, 32'(frameError),      32'(expFrameErr));
        checkOutput({tag, ".busy"},     32'(busy),            32'(expBusy));
    endtask

    // One line bit per clock: drive at negedge, update the model at the
    // posedge from what this edge means for the frame, check at next negedge.
    task automatic applyStimulus(input string tag, input logic lineVal, input logic ackVal,
                                 input logic completes, input logic badStop,
                                 input logic [DB-1:0] frameByte, input logic busyAfter);
        serialDataIn = lineVal;
        dataAck      = ackVal;
        @(posedge dataClk);
        if (completes) begin
            if (ackVal)        expOverrun = 1'b0;
            else if (expValid) expOverrun = 1'b1;
            expData  = frameByte;
            expValid = 1'b1;
        end else if (ackVal && expValid) begin
            expValid   = 1'b0;
            expOverrun = 1'b0;
        end
        expFrameErr = badStop;
        expBusy     = busyAfter;
        @(negedge dataClk);
        checkAll(tag);
    endtask

    task automatic idle(input int n, input logic randAck);
        for (int i = 0; i < n; i++)
            applyStimulus("idle", 1'b1, randAck ? 1'(($urandom_range(0, 1))) : 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic ackPulse();
        applyStimulus("ack", 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic sendFrame(input logic [DB-1:0] d, input logic stopBit, input logic ackAtEnd,
                             input logic randAck, input logic withStop);
        logic lastAck;
        lastAck = withStop ? 1'b0 : ackAtEnd;
        applyStimulus("start", 1'b0, randAck ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, 1'b0, d, 1'b1);
        for (int i = 0; i < DB; i++) begin
            logic ackNow;
            ackNow = randAck ? 1'($urandom_range(0, 1)) : 1'b0;
            if (i == DB - 1 && !STOP_CHECK) ackNow = lastAck | (randAck & ackNow & withStop);
            applyStimulus("data", d[DB-1-i], ackNow, (i == DB - 1) && !STOP_CHECK, 1'b0, d,
                          (i != DB - 1) || STOP_CHECK);
        end
        if (withStop)
            applyStimulus("stop", STOP_CHECK ? stopBit : 1'b1, STOP_CHECK ? ackAtEnd : 1'b0,
                          STOP_CHECK && stopBit, STOP_CHECK && !stopBit, d, 1'b0);
    endtask

    // Reset is asynchronous, so the cleared outputs are checked before any edge.
    task automatic doReset();
        rst          = 1'b1;
        serialDataIn = 1'b1;
        dataAck      = 1'b0;
        #1;
        expData = '0; expValid = 1'b0; expOverrun = 1'b0; expFrameErr = 1'b0; expBusy = 1'b0;
        checkAll("asyncReset");
        @(negedge dataClk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DB-1:0] partial;
        rst = 1'b1; serialDataIn = 1'b1; dataAck = 1'b0;
        expData = '0; expValid = 1'b0; expOverrun = 1'b0; expFrameErr = 1'b0; expBusy = 1'b0;
        repeat (2) @(negedge dataClk);
        checkAll("reset");
        rst = 1'b0;
        idle(2, 1'b0);

        sendFrame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);
        sendFrame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);
        ackPulse();
        ackPulse();

        sendFrame(8'h11, 1'b1, 1'b0, 1'b0, STOP_CHECK);
        sendFrame(8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b0);
        ackPulse();

        sendFrame(8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
        sendFrame(8'h7E, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(1, 1'b0);
        ackPulse();

        partial = 8'hF0;
        applyStimulus("rstStart", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++)
            applyStimulus("rstData", partial[DB-1-i], 1'b0, 1'b0, 1'b0, '0, 1'b1);
        doReset();
        idle(1, 1'b0);
        sendFrame(8'h81, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);
        ackPulse();

        for (int n = 0; n < 30; n++) begin
            sendFrame(DB'($urandom), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
            idle($urandom_range(0, 2), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/serial_receiver.md
SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 Parameter: DATA_BITS, default 8, number of data bits per frame.
REQ-002 Port: rst  input  1  reset, asynchronous, active-high.
REQ-003 Port: dataClk  input  1  clock; all state updates and serial samples occur on its rising edge.
REQ-004 Port: serialDataIn  input  1  serial line; idle high, one start bit (0), DATA_BITS data bits MSB first, stop bit (1).
REQ-005 Port: dataAck  input  1  consumer acknowledge; clears dataValid and overrun.
REQ-006 Port: parallelDataOut  output  DATA_BITS  last received byte, registered.
REQ-007 Port: dataValid  output  1  high while parallelDataOut holds an unacknowledged byte.
REQ-008 Port: frameError  output  1  one-cycle pulse on a bad stop bit.
REQ-009 Port: overrun  output  1  sticky; a byte completed while dataValid was still high.
REQ-010 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT and STOP; STOP exists only when SERIAL_RX_STOP_CHECK_EN is defined.
REQ-012 IDLE: sample 0 -> SHIFT with bit counter = 0; sample 1 -> stay in IDLE.
REQ-013 SHIFT: each edge shifts the sample into the LSB of an internal shift register (MSB-first assembly) and increments the counter.
REQ-014 On the DATA_BITS-th data sample the FSM SHALL go to STOP; without the macro it SHALL complete the byte and return to IDLE.
REQ-015 STOP, sample 1: complete the byte, then go to IDLE.
REQ-016 STOP, sample 0: pulse frameError for one cycle, discard the byte, leave parallelDataOut, dataValid and overrun unchanged, then go to IDLE.
REQ-017 Completing a byte SHALL load parallelDataOut and set dataValid on the same edge; outputs are visible one cycle after the completing sample.
REQ-018 Latency from the start-bit sample edge to dataValid: DATA_BITS+1 edges with the macro, DATA_BITS edges without it.
REQ-019 dataAck sampled high with dataValid high and no completion on that edge: clear dataValid and overrun.
REQ-020 dataAck sampled high with dataValid low SHALL be ignored.
REQ-021 Completion on the same edge as dataAck: the new byte loads, dataValid stays 1, overrun is cleared.
REQ-022 Completion with dataValid=1 and dataAck=0: overwrite parallelDataOut and set overrun; overrun holds until acknowledged.
REQ-023 A start bit sampled on the edge immediately after returning to IDLE SHALL be accepted (back-to-back frames).
REQ-024 The bit counter SHALL be ceil(log2(DATA_BITS+1)) bits wide and never wrap within a frame.

Reset
REQ-025 rst high SHALL immediately force: state IDLE, counter 0, shift register 0, parallelDataOut 0, dataValid 0, frameError 0, overrun 0, busy 0.
REQ-026 Reset mid-frame SHALL abandon the partial byte without asserting any flag; reception restarts at the next 0 sampled after rst deasserts.

Configuration
REQ-027 Macro SERIAL_RX_STOP_CHECK_EN defined: STOP state present, stop bit checked, frameError driven per REQ-016.
REQ-028 Macro SERIAL_RX_STOP_CHECK_EN undefined: no STOP state, bytes complete on the last data bit, frameError tied to 0, busy drops one edge earlier.

Verification
REQ-029 Macro on, line 1,0,1,0,1,0,0,1,0,1,1 (start, 0xA5, stop) -> parallelDataOut=0xA5, dataValid=1 one cycle after the stop sample, frameError=0.
REQ-030 Macro on, frame 0x3C with stop sample 0 -> one-cycle frameError pulse; dataValid and parallelDataOut unchanged (0, 0x00 after reset).
REQ-031 Two back-to-back frames 0x11, 0x22 with no ack -> parallelDataOut=0x22, dataValid=1, overrun=1; dataAck high for one cycle -> dataValid=0, overrun=0.
REQ-032 dataAck held high on the exact completion edge of 0x7E -> dataValid=1, parallelDataOut=0x7E, overrun=0.
REQ-033 rst pulsed after 4 data bits of 0xF0, then a full frame 0x81 -> only 0x81 received, no flags, no spurious dataValid.
REQ-034 Macro off, frame 0xA5 with the line held 0 after the last data bit -> dataValid=1 one cycle after the d0 sample, frameError stays 0, next 0 starts a new frame.
